// File: rtl/transpose_ctrl.sv
// rtl/transpose_ctrl.sv - ping-pong 8x8 transpose buffer sequencer between row and column DCT passes
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   flush      synchronous clear of all sequencing state (highest priority)
//   in_valid   row-pass DCT presents a row
//   in_ready   a row can be accepted this cycle (write bank not full)
//   t_wr       buffer write strobe
//   wr_bank    bank being written
//   wr_row     row index for t_wr
//   t_rd       buffer read strobe, column data appears on the buffer output next cycle
//   rd_bank    bank being read
//   rd_col     column index for t_rd
//   out_valid  buffer output holds a valid column
//   out_ready  column-pass DCT accepts the column
//   out_last   current output column is the last column of a block
//   occupancy  number of banks marked full (0..2)

module transpose_ctrl #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          t_wr,
    output logic          wr_bank,
    output logic [IW-1:0] wr_row,
    output logic          t_rd,
    output logic          rd_bank,
    output logic [IW-1:0] rd_col,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [1:0]    occupancy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_last;
    logic       rd_last;

    assign wr_last   = (wr_row == LAST_IDX);
    assign rd_last   = (rd_col == LAST_IDX);

    assign in_ready  = ~full[wr_bank];
    assign t_wr      = in_valid & in_ready & ~flush;
    // A read is issued whenever the output register is empty or being drained.
    assign t_rd      = full[rd_bank] & (~out_valid | out_ready) & ~flush;
    assign occupancy = {1'b0, full[0]} + {1'b0, full[1]};

    // The write side only sets a bank it owns (not full) and the read side only
    // clears a bank that is full, so both updates never target the same bank.
    always_comb begin
        full_nxt = full;
        if (t_wr && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (t_rd && rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            wr_row    <= '0;
            rd_bank   <= 1'b0;
            rd_col    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (flush) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            wr_row    <= '0;
            rd_bank   <= 1'b0;
            rd_col    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            full <= full_nxt;

            if (t_wr) begin
                if (wr_last) begin
                    wr_row  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_row  <= wr_row + IW'(1);
                end
            end

            if (t_rd) begin
                if (rd_last) begin
                    rd_col  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_col  <= rd_col + IW'(1);
                end
            end

            // Output register tracks the buffer's registered read data.
            if (t_rd) begin
                out_valid <= 1'b1;
                out_last  <= rd_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_transpose_ctrl.sv
// tb/tb_transpose_ctrl.sv - self-checking bench for transpose_ctrl

module tb_transpose_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, t_wr, wr_bank, t_rd, rd_bank, out_valid, out_last;
    logic [2:0] wr_row, rd_col;
    logic [1:0] occupancy;

    transpose_ctrl #(.N(8), .IW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .t_wr      (t_wr),
        .wr_bank   (wr_bank),
        .wr_row    (wr_row),
        .t_rd      (t_rd),
        .rd_bank   (rd_bank),
        .rd_col    (rd_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a completed block of 8 accepted rows pushes its 8 expected
    // columns; each output handshake pops one and compares it.
    typedef struct packed {
        logic       bank;
        logic [2:0] col;
        logic       last;
    } col_t;

    col_t       sb[$];
    col_t       exp_e;
    col_t       new_e;
    int         wcnt = 0;
    int         hs = 0;
    logic       buf_bank = 1'b0;
    logic [2:0] buf_col = 3'd0;

    task automatic sb_clear();
        sb.delete();
        wcnt     = 0;
        hs       = 0;
        buf_bank = 1'b0;
        buf_col  = 3'd0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("t_wr_rule", t_wr, in_valid & in_ready & ~flush);
            if (t_wr) begin
                chk("wr_row_seq", wr_row, wcnt % 8);
                chk("wr_bank_seq", wr_bank, (wcnt / 8) % 2);
                wcnt++;
                if (wcnt % 8 == 0) begin
                    for (int j = 0; j < 8; j++) begin
                        new_e.bank = ((wcnt / 8) - 1) % 2;
                        new_e.col  = 3'(j);
                        new_e.last = (j == 7);
                        sb.push_back(new_e);
                    end
                end
            end
            if (out_valid && out_ready) begin
                hs++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_e = sb.pop_front();
                    chk("sb_column", {buf_bank, buf_col, out_last}, exp_e);
                end
            end
            if (out_valid && !out_ready) begin
                chk("stall_no_rd", t_rd, 0);
            end
            // Emulated buffer: the column read at t_rd sits on the output next cycle.
            if (t_rd) begin
                buf_bank = rd_bank;
                buf_col  = rd_col;
            end
            if (flush) begin
                sb.delete();
                wcnt = 0;
            end
        end
    end

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       inr;
        logic       twr;
        logic [2:0] wrow;
        logic       wbank;
        logic       trd;
        logic [2:0] rcol;
        logic       rbank;
        logic       ov;
        logic       ol;
        logic [1:0] occ;
    } vec_t;

    vec_t tbl[18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    int   k;
    int   drops;
    int   run;
    int   first;
    bit   found;
    logic ov_hist[64];

    initial begin
        for (int c = 0; c < 18; c++) begin
            tbl[c].iv    = (c < 8);
            tbl[c].ordy  = 1'b1;
            tbl[c].inr   = 1'b1;
            tbl[c].twr   = (c < 8);
            tbl[c].wrow  = (c < 8) ? 3'(c) : 3'd0;
            tbl[c].wbank = (c < 8) ? 1'b0 : 1'b1;
            tbl[c].trd   = (c >= 8 && c <= 15);
            tbl[c].rcol  = (c >= 8 && c <= 15) ? 3'(c - 8) : 3'd0;
            tbl[c].rbank = (c <= 15) ? 1'b0 : 1'b1;
            tbl[c].ov    = (c >= 9 && c <= 16);
            tbl[c].ol    = (c == 16);
            tbl[c].occ   = (c >= 8 && c <= 15) ? 2'd1 : 2'd0;
        end

        // Reset state
        reset_dut();
        @(negedge clk);
        chk("reset_state",
            {in_ready, t_wr, wr_row, wr_bank, t_rd, rd_col, rd_bank, out_valid, out_last, occupancy},
            15'h4000);

        // Single block through, out_ready=1
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl[%0d]", i),
                {in_ready, t_wr, wr_row, wr_bank, t_rd, rd_col, rd_bank, out_valid, out_last, occupancy},
                {tbl[i].inr, tbl[i].twr, tbl[i].wrow, tbl[i].wbank, tbl[i].trd, tbl[i].rcol,
                 tbl[i].rbank, tbl[i].ov, tbl[i].ol, tbl[i].occ});
        end
        step();
        chk("t1_hs", hs, 8);

        // Continuous streaming of three blocks
        reset_dut();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drops = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 24) in_valid = 1'b0;
            @(negedge clk);
            if (c < 24 && !in_ready) drops++;
            ov_hist[c] = out_valid;
            step();
        end
        first = -1;
        run = 0;
        for (int c = 0; c < 60; c++) begin
            if (first < 0 && ov_hist[c]) first = c;
        end
        if (first >= 0) begin
            for (int c = first; c < 60 && ov_hist[c]; c++) run++;
        end
        chk("t2_in_ready_drops", drops, 0);
        chk("t2_first_ov", first, 9);
        chk("t2_ov_run", run, 24);
        chk("t2_hs", hs, 24);

        // Output stalled: both banks fill, one column held
        reset_dut();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (20) step();
        @(negedge clk);
        chk("t3_stalled",
            {occupancy, in_ready, t_wr, out_valid, rd_col, t_rd, rd_bank},
            {2'd2, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
        chk("t3_writes", wcnt, 16);
        step();
        out_ready = 1'b1;
        found = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk("t3_released", found, 1);
        chk("t3_release_cycle", k, 7);
        chk("t3_after_release", {occupancy, rd_bank, wr_bank}, {2'd1, 1'b1, 1'b0});
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("t3_hs", hs, 16);
        chk("t3_sb_empty", sb.size(), 0);

        // out_ready toggling during drain
        reset_dut();
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 2 == 0);
            in_valid  = (c < 8);
            step();
        end
        chk("t4_hs", hs, 8);
        chk("t4_sb_empty", sb.size(), 0);

        // Flush after five writes
        reset_dut();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (5) step();
        flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_no_twr", t_wr, 0);
        chk("t5_flush_wr_row", wr_row, 5);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_after_flush", {wr_row, wr_bank, occupancy, in_ready}, {3'd0, 1'b0, 2'd0, 1'b1});
        step();
        in_valid = 1'b1;
        repeat (8) step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("t5_hs", hs, 8);

        // Asynchronous reset mid-drain
        reset_dut();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (8) step();
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid && rd_col == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_reach_col3", found, 1);
        #2;
        rst = 1'b0;
        sb_clear();
        #1;
        chk("t6_async_reset",
            {in_ready, t_wr, wr_row, wr_bank, t_rd, rd_col, rd_bank, out_valid, out_last, occupancy},
            15'h4000);
        @(posedge clk);
        #1;
        chk("t6_held_in_reset", {t_rd, t_wr, out_valid}, 3'b000);
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (8) step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("t6_hs_after_reset", hs, 8);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
